// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit: fixed-latency busy window, results commit as busy falls.
// Optional macro MULT_DIV_UNIT_MADD_EN enables madd/maddu/msub/msubu accumulation ops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MD_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5, OP_MFLO  = 4'd6, OP_MTHI = 4'd7, OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11, OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        is_md, is_div, accept;
  logic [63:0] prod_s, prod_u, res;
  logic signed [31:0] sa, sb, q_s, r_s;

  assign is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
`ifdef MULT_DIV_UNIT_MADD_EN
  assign is_md = (MDOp >= OP_MULT && MDOp <= OP_DIVU) || (MDOp >= OP_MADD && MDOp <= OP_MSUBU);
`else
  assign is_md = (MDOp >= OP_MULT && MDOp <= OP_DIVU);
`endif
  assign accept = start && !busy && is_md;

  // Low 64 bits of the extended product are exact for both signednesses.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign sa  = a_q;
  assign sb  = b_q;
  assign q_s = sa / sb;
  assign r_s = sa % sb;

  always_comb begin
    res = {HI, LO};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (b_q != 32'd0) res = {r_s, q_s};
      OP_DIVU:  if (b_q != 32'd0) res = {a_q % b_q, a_q / b_q};
`ifdef MULT_DIV_UNIT_MADD_EN
      OP_MADD:  res = {HI, LO} + prod_s;
      OP_MADDU: res = {HI, LO} + prod_u;
      OP_MSUB:  res = {HI, LO} - prod_s;
      OP_MSUBU: res = {HI, LO} - prod_u;
`endif
      default:  res = {HI, LO};
    endcase
  end

  always_comb begin
    MD_out = 32'd0;
    if (MDOp == OP_MFHI) MD_out = HI;
    else if (MDOp == OP_MFLO) MD_out = LO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 16'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 4'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= MDOp;
            cnt   <= is_div ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
            state <= RUN;
            busy  <= 1'b1;
          end else if (MDOp == OP_MTHI) begin
            HI <= A;
          end else if (MDOp == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          // Counter value 1 marks the last busy cycle; commit at its closing edge.
          if (cnt == 16'd1) begin
            {HI, LO} <= res;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy;
  logic [31:0] MD_out, HI, LO;

  int checks = 0;
  int failures = 0;
  logic [63:0] hl = 64'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .MD_out(MD_out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit madd_en();
`ifdef MULT_DIV_UNIT_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lat(input logic [3:0] op);
    if (op == 4'd3 || op == 4'd4) return 10;
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op >= 4'd9 && op <= 4'd12 && madd_en()) return 5;
    return 0;
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] cur);
    int ia, ib, q, r;
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    ia = a; ib = b;
    sa = ia; sb = ib; sp = sa * sb;
    ua = a;  ub = b;  up = ua * ub;
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 0) return cur;
        q = ia / ib; r = ia % ib;
        return {r, q};
      end
      4'd4: return (b == 0) ? cur : {a % b, a / b};
      4'd9:  return cur + sp;
      4'd10: return cur + up;
      4'd11: return cur - sp;
      4'd12: return cur - up;
      default: return cur;
    endcase
  endfunction

  task automatic check_mdout();
    MDOp = 4'd5; #1; chk("mfhi", MD_out, hl[63:32]);
    MDOp = 4'd6; #1; chk("mflo", MD_out, hl[31:0]);
    MDOp = 4'd0; #1; chk("md_none", MD_out, 64'd0);
  endtask

  // poke: keep throwing starts and mthi at the unit while it is busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int n;
    logic [63:0] exp;
    n = lat(op);
    exp = (n == 0) ? hl : ref_calc(op, a, b, hl);
    start = 1'b1; MDOp = op; A = a; B = b;
    chk("busy_at_start", busy, 64'd0);
    cyc();
    start = 1'b0; MDOp = 4'd0;
    for (int i = 1; i <= n; i++) begin
      if (poke) begin start = 1'b1; MDOp = (i % 2 == 1) ? 4'd7 : 4'd3; end
      A = $urandom; B = $urandom;
      chk("busy_run", busy, 64'd1);
      chk("hilo_hold", {HI, LO}, hl);
      cyc();
    end
    start = 1'b0; MDOp = 4'd0;
    chk("busy_done", busy, 64'd0);
    hl = exp;
    chk("hilo_result", {HI, LO}, hl);
  endtask

  task automatic write_mt(input logic [3:0] op, input logic [31:0] v);
    start = 1'b1; MDOp = op; A = v;
    cyc();
    start = 1'b0; MDOp = 4'd0;
    if (op == 4'd7) hl[63:32] = v; else hl[31:0] = v;
    chk("mt_busy", busy, 64'd0);
    chk("mt_hilo", {HI, LO}, hl);
  endtask

  initial begin
    logic [3:0] ops[$];
    logic [3:0] op;
    logic [31:0] a, b;

    repeat (3) cyc();
    chk("rst_busy", busy, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    // Reset wins over a simultaneous mthi.
    start = 1'b1; MDOp = 4'd7; A = 32'hDEAD_BEEF;
    cyc();
    chk("rst_prio", {HI, LO}, 64'd0);
    start = 1'b0; MDOp = 4'd0; reset = 1'b0;
    cyc();

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", HI, 64'hFFFF_FFFF);
    chk("mult_lo", LO, 64'hFFFF_FFFA);
    check_mdout();

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", LO, 64'hFFFF_FFFD);
    chk("div_hi", HI, 64'hFFFF_FFFF);
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("divu_lo", LO, 64'h7FFF_FFFC);
    chk("divu_hi", HI, 64'd1);

    write_mt(4'd7, 32'h1234);
    write_mt(4'd8, 32'h5678);
    run_op(4'd4, 32'hCAFE_0001, 32'd0, 1'b0);
    chk("divz_hi", HI, 64'h1234);
    chk("divz_lo", LO, 64'h5678);
    run_op(4'd3, 32'h8000_0000, 32'd0, 1'b0);
    chk("divz_s", {HI, LO}, 64'h0000_1234_0000_5678);

    // Second start and mthi during busy must be ignored.
    run_op(4'd2, 32'h0001_0003, 32'h0002_0005, 1'b1);
    chk("restart_lo", LO, 64'h000B_000F);
    chk("restart_hi", HI, 64'h0000_0002);

    // Reset in the 3rd busy cycle of a multu.
    start = 1'b1; MDOp = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    cyc();
    start = 1'b0; MDOp = 4'd0;
    cyc(); cyc();
    chk("pre_rst_busy", busy, 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    hl = 64'd0;
    chk("midrst_busy", busy, 64'd0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_busy", busy, 64'd0);
      chk("post_rst_hilo", {HI, LO}, 64'd0);
      cyc();
    end

    write_mt(4'd7, 32'd0);
    write_mt(4'd8, 32'hFFFF_FFFF);
    run_op(4'd10, 32'd1, 32'd1, 1'b0);
    if (madd_en()) chk("maddu", {HI, LO}, 64'h0000_0001_0000_0000);
    else           chk("maddu_off", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
    check_mdout();

    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    if (madd_en()) begin
      ops.push_back(4'd9); ops.push_back(4'd10); ops.push_back(4'd11); ops.push_back(4'd12);
    end
    for (int k = 0; k < 30; k++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 5) == 0) b = 32'd0;
      if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if (op == 4'd7 || op == 4'd8) write_mt(op, a);
      else run_op(op, a, b, k[0]);
    end
    check_mdout();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
